drive_cmd_executor: RTL and testbench

// - Consumer end of the manual-driving command bus: takes the 8-bit drive command byte and the power flag.
// - Turns them into ramped left/right motor PWM, a committed wheel direction and blinking turn indicators.
// - Sits between the driving-mode controllers and the car chassis/motor pins.
// - Enforces a safe reversal: speed ramps to zero before the direction flips.

---
 rtl/drive_pkg.sv | 27 ++
 rtl/tick_divider.sv | 28 ++
 rtl/drive_cmd_executor.sv | 148 ++++++++++++++
 tb/tb_drive_cmd_executor.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared field positions, command encodings and FSM states for the drive command bus.
package drive_pkg;

  localparam int CMD_BF_LSB  = 0;
  localparam int CMD_BF_MSB  = 1;
  localparam int CMD_TLR_LSB = 2;
  localparam int CMD_TLR_MSB = 3;

  localparam logic [1:0] BF_FWD  = 2'b01;
  localparam logic [1:0] BF_REV  = 2'b10;
  localparam logic [1:0] TLR_L   = 2'b01;
  localparam logic [1:0] TLR_R   = 2'b10;
  localparam logic [1:0] TLR_HAZ = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } state_t;

  // Only a clean fwd or rev code is a direction request; 00/11 mean stop.
  function automatic logic [1:0] req_dir(input logic [1:0] bf);
    return (bf == BF_FWD || bf == BF_REV) ? bf : 2'b00;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter emitting a one-cycle tick on its last count.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q;

  // A clear restarts the period, so it also suppresses a coincident tick.
  assign tick_o = (cnt_q == W'(DIV - 1)) && !clr_i;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/drive_cmd_executor.sv
// Turns the registered drive command byte and power flag into ramped differential
// motor PWM, a committed wheel direction and blinking turn indicators.
module drive_cmd_executor
  import drive_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int RAMP_DIV   = 100_000,
  parameter int BLINK_DIV  = 50_000_000,
  parameter int TURN_SHIFT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd,
  input  logic       p,
  output logic [1:0] motor_dir,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       led_l,
  output logic       led_r,
  output logic       moving
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [3:0]          cmd_q;
  logic                p_q;
  logic [1:0]          tlr_prev_q;
  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [1:0]          dir_q, dir_d;
  logic [PWM_BITS-1:0] duty_l_d, duty_r_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                pwm_l_q, pwm_r_q, moving_q, blink_ph_q;
  logic                ramp_tick, blink_tick, turn_start;
  logic [1:0]          req, tlr;
  logic                unused_cmd_hi;

  assign unused_cmd_hi = ^cmd[7:4];
  assign req           = req_dir(cmd_q[CMD_BF_MSB:CMD_BF_LSB]);
  assign tlr           = cmd_q[CMD_TLR_MSB:CMD_TLR_LSB];
  assign turn_start    = (tlr != 2'b00) && (tlr_prev_q == 2'b00);

  tick_divider #(.DIV(RAMP_DIV)) u_ramp_div (
    .clk(clk), .rst(rst), .clr_i(1'b0), .tick_o(ramp_tick)
  );

  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clk(clk), .rst(rst), .clr_i(turn_start), .tick_o(blink_tick)
  );

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    if (!p_q) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      dir_d   = 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          dir_d  = 2'b00;
          if (req != 2'b00) begin
            dir_d   = req;
            state_d = ST_ACCEL;
          end
        end
        ST_ACCEL: begin
          if (req != dir_q) begin
            state_d = ST_DECEL;
          end else begin
            if (ramp_tick && duty_q != DUTY_MAX) duty_d = duty_q + 1'b1;
            if (duty_d == DUTY_MAX) state_d = ST_CRUISE;
          end
        end
        ST_CRUISE: begin
          duty_d = DUTY_MAX;
          if (req != dir_q) state_d = ST_DECEL;
        end
        ST_DECEL: begin
          // Direction may only be re-committed once the wheels are stopped.
          if (req == dir_q) begin
            state_d = ST_ACCEL;
          end else if (duty_q == '0) begin
            dir_d   = req;
            state_d = (req == 2'b00) ? ST_IDLE : ST_ACCEL;
          end else if (ramp_tick) begin
            duty_d = duty_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
          dir_d   = 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    duty_l_d = duty_d;
    duty_r_d = duty_d;
    case (tlr)
      TLR_L:   duty_l_d = duty_d >> TURN_SHIFT;
      TLR_R:   duty_r_d = duty_d >> TURN_SHIFT;
      default: ;
    endcase
  end

  // PWM and moving follow next-state duty so they settle on the same edge as duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= '0;
      p_q        <= 1'b0;
      tlr_prev_q <= 2'b00;
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      dir_q      <= 2'b00;
      pwm_cnt_q  <= '0;
      pwm_l_q    <= 1'b0;
      pwm_r_q    <= 1'b0;
      moving_q   <= 1'b0;
      blink_ph_q <= 1'b0;
    end else begin
      cmd_q      <= cmd[3:0];
      p_q        <= p;
      tlr_prev_q <= tlr;
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
      pwm_l_q    <= (pwm_cnt_q < duty_l_d);
      pwm_r_q    <= (pwm_cnt_q < duty_r_d);
      moving_q   <= (duty_d != '0);
      if (turn_start)      blink_ph_q <= 1'b1;
      else if (blink_tick) blink_ph_q <= ~blink_ph_q;
    end
  end

  assign motor_dir = dir_q;
  assign pwm_l     = pwm_l_q;
  assign pwm_r     = pwm_r_q;
  assign moving    = moving_q;
  assign led_l     = blink_ph_q && (tlr == TLR_L || tlr == TLR_HAZ);
  assign led_r     = blink_ph_q && (tlr == TLR_R || tlr == TLR_HAZ);

endmodule

// File: tb/tb_drive_cmd_executor.sv
// Directed bench for drive_cmd_executor with a short PWM period and fast dividers.
module tb_drive_cmd_executor;
  import drive_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd;
  logic       p;
  logic [1:0] motor_dir;
  logic       pwm_l, pwm_r, led_l, led_r, moving;

  int checks = 0;
  int errors = 0;

  drive_cmd_executor #(
    .PWM_BITS(4), .RAMP_DIV(2), .BLINK_DIV(4), .TURN_SHIFT(1)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .p(p),
    .motor_dir(motor_dir), .pwm_l(pwm_l), .pwm_r(pwm_r),
    .led_l(led_l), .led_r(led_r), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic measure(output int nl, output int nr);
    nl = 0;
    nr = 0;
    repeat (16) begin
      step(1);
      nl += int'(pwm_l);
      nr += int'(pwm_r);
    end
  endtask

  initial begin
    int nl, nr, bad, found;

    // Reset holds everything low even with a run command present.
    rst = 1'b1; cmd = 8'h01; p = 1'b1;
    step(3);
    chk("rst_dir", int'(motor_dir), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_pwm_l", int'(pwm_l), 0);
    chk("rst_pwm_r", int'(pwm_r), 0);
    chk("rst_led_l", int'(led_l), 0);
    chk("rst_led_r", int'(led_r), 0);
    rst = 1'b0;
    step(2);
    chk("start_dir_fwd", int'(motor_dir), 1);
    step(40);
    measure(nl, nr);
    chk("cruise_pwm_l", nl, 15);
    chk("cruise_pwm_r", nr, 15);
    chk("cruise_moving", int'(moving), 1);

    // Reversal: direction must hold until the wheels stop.
    cmd = 8'h02;
    bad = 0; found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step(1);
      if (moving == 1'b0) found = 1;
      else if (motor_dir != 2'b01) bad = 1;
    end
    chk("rev_stop_seen", found, 1);
    chk("rev_dir_held", bad, 0);
    chk("rev_dir_at_zero", int'(motor_dir), 1);
    step(1);
    chk("rev_dir_flip", int'(motor_dir), 2);
    step(40);
    measure(nl, nr);
    chk("rev_pwm_l", nl, 15);
    chk("rev_pwm_r", nr, 15);

    // Forward plus left turn: inner (left) wheel at half duty.
    cmd = 8'h05;
    step(80);
    measure(nl, nr);
    chk("left_pwm_l", nl, 7);
    chk("left_pwm_r", nr, 15);
    chk("left_dir", int'(motor_dir), 1);
    chk("left_led_r", int'(led_r), 0);

    // Emergency stop.
    p = 1'b0;
    step(1);
    chk("estop_p_q_only", int'(moving), 1);
    step(1);
    chk("estop_moving", int'(moving), 0);
    chk("estop_dir", int'(motor_dir), 0);
    chk("estop_pwm_l", int'(pwm_l), 0);
    chk("estop_pwm_r", int'(pwm_r), 0);
    cmd = 8'h01;
    step(5);
    chk("estop_hold_moving", int'(moving), 0);
    chk("estop_hold_dir", int'(motor_dir), 0);
    p = 1'b1;
    step(2);
    chk("restart_dir", int'(motor_dir), 1);

    // Hazard lights: both LEDs together, high first, 4 clk per phase.
    cmd = 8'h0D;
    step(2);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("haz_l_%0d", i), int'(led_l), ((i / 4) % 2 == 0) ? 1 : 0);
      chk($sformatf("haz_r_%0d", i), int'(led_r), int'(led_l));
      step(1);
    end
    cmd = 8'h01;
    step(1);
    chk("haz_off_l", int'(led_l), 0);
    chk("haz_off_r", int'(led_r), 0);

    // Reset asserted mid-deceleration at duty 9.
    step(40);
    cmd = 8'h00;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step(1);
      if (dut.duty_q == 4'd9) found = 1;
    end
    chk("decel9_seen", found, 1);
    chk("decel9_state", int'(dut.state_q), int'(ST_DECEL));
    rst = 1'b1;
    step(1);
    chk("midrst_duty", int'(dut.duty_q), 0);
    chk("midrst_state", int'(dut.state_q), int'(ST_IDLE));
    chk("midrst_pwm_cnt", int'(dut.pwm_cnt_q), 0);
    chk("midrst_moving", int'(moving), 0);
    chk("midrst_dir", int'(motor_dir), 0);
    rst = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
